// File: rtl/hazard_scheduler_pkg.sv
// rtl/hazard_scheduler_pkg.sv - shared types and constants for the hazard scheduler
package hazard_scheduler_pkg;

  localparam int MIPS_REG_ADDR_W = 3;
  localparam logic [MIPS_REG_ADDR_W-1:0] MIPS_REG_ZERO = 3'd0;
  localparam int MIPS_MAX_STALL = 3;

  // One in-flight destination slot of the scoreboard.
  typedef struct packed {
    logic                       valid;
    logic [MIPS_REG_ADDR_W-1:0] dest;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, dest: '0};

  // A source collides with a slot when it is read, the slot holds a real
  // write to the same register, and the source is not the hardwired zero.
  function automatic logic sb_match(input sb_entry_t                  e,
                                    input logic                       used,
                                    input logic [MIPS_REG_ADDR_W-1:0] src,
                                    input logic                       r0_is_zero);
    return used && e.valid && (e.dest == src) &&
           !(r0_is_zero && (src == MIPS_REG_ZERO));
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// rtl/hazard_scheduler_if.sv - ID-stage decode/stall bundle between pipeline and scheduler
interface hazard_scheduler_if #(
  parameter int PERF_W = 16
);
  import hazard_scheduler_pkg::*;

  logic [MIPS_REG_ADDR_W-1:0] decoding_op_src1;
  logic                       src1_used;
  logic [MIPS_REG_ADDR_W-1:0] decoding_op_src2;
  logic                       src2_used;
  logic [MIPS_REG_ADDR_W-1:0] id_op_dest;
  logic                       id_write_en;
  logic                       branch_taken;
  logic                       pipeline_stall_n;
  logic [MIPS_REG_ADDR_W-1:0] ex_op_dest;
  logic [MIPS_REG_ADDR_W-1:0] mem_op_dest;
  logic [MIPS_REG_ADDR_W-1:0] wb_op_dest;
  logic [PERF_W-1:0]          stall_total;
  logic                       stall_timeout;

  // Pipeline side: presents the ID instruction, consumes the stall.
  modport master (
    output decoding_op_src1, src1_used, decoding_op_src2, src2_used,
           id_op_dest, id_write_en, branch_taken,
    input  pipeline_stall_n, ex_op_dest, mem_op_dest, wb_op_dest,
           stall_total, stall_timeout
  );

  // Scheduler side.
  modport slave (
    input  decoding_op_src1, src1_used, decoding_op_src2, src2_used,
           id_op_dest, id_write_en, branch_taken,
    output pipeline_stall_n, ex_op_dest, mem_op_dest, wb_op_dest,
           stall_total, stall_timeout
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - 3-deep in-flight destination shift register and source comparators
module hazard_scoreboard
  import hazard_scheduler_pkg::*;
#(
  parameter int REG_ADDR_W = MIPS_REG_ADDR_W,
  parameter int R0_IS_ZERO = 1,
  parameter int WB_BYPASS  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic                  src1_used,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  src2_used,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_write_en,
  input  logic                  insert_bubble,
  output sb_entry_t             ex_q,
  output sb_entry_t             mem_q,
  output sb_entry_t             wb_q,
  output logic                  match
);

  localparam logic R0Z = (R0_IS_ZERO != 0);

  // Advance the pipeline shadow every cycle; EX takes a bubble when the
  // ID instruction is held back or squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= SB_BUBBLE;
      mem_q <= SB_BUBBLE;
      wb_q  <= SB_BUBBLE;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (insert_bubble) begin
        ex_q <= SB_BUBBLE;
      end else begin
        ex_q <= '{valid: id_write_en, dest: id_dest};
      end
    end
  end

  // Any read source hitting any eligible in-flight write; WB is skipped when
  // the register file writes through in the same cycle.
  always_comb begin
    match = 1'b0;
    match = match | sb_match(ex_q,  src1_used, src1, R0Z);
    match = match | sb_match(ex_q,  src2_used, src2, R0Z);
    match = match | sb_match(mem_q, src1_used, src1, R0Z);
    match = match | sb_match(mem_q, src2_used, src2, R0Z);
    if (WB_BYPASS == 0) begin
      match = match | sb_match(wb_q, src1_used, src1, R0Z);
      match = match | sb_match(wb_q, src2_used, src2, R0Z);
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - central stall scheduler with branch squash, watchdog and stall counter
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int REG_ADDR_W = MIPS_REG_ADDR_W,
  parameter int R0_IS_ZERO = 1,
  parameter int WB_BYPASS  = 0,
  parameter int MAX_STALL  = MIPS_MAX_STALL,
  parameter int PERF_W     = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_scheduler_if.slave bus
);

  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  sb_entry_t         ex_q;
  sb_entry_t         mem_q;
  sb_entry_t         wb_q;
  logic              match;
  logic              hazard;
  logic              squash_q;
  logic [2:0]        consec_q;
  logic              timeout_q;
  logic [PERF_W-1:0] stall_cnt_q;

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .R0_IS_ZERO (R0_IS_ZERO),
    .WB_BYPASS  (WB_BYPASS)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .src1          (bus.decoding_op_src1),
    .src1_used     (bus.src1_used),
    .src2          (bus.decoding_op_src2),
    .src2_used     (bus.src2_used),
    .id_dest       (bus.id_op_dest),
    .id_write_en   (bus.id_write_en),
    .insert_bubble (hazard | squash_q),
    .ex_q          (ex_q),
    .mem_q         (mem_q),
    .wb_q          (wb_q),
    .match         (match)
  );

  // The instruction in the branch shadow is dropped, so it may never stall.
  assign hazard = match & ~squash_q;

  assign bus.pipeline_stall_n = ~hazard;
  assign bus.ex_op_dest       = ex_q.dest;
  assign bus.mem_op_dest      = mem_q.dest;
  assign bus.wb_op_dest       = wb_q.dest;
  assign bus.stall_total      = stall_cnt_q;
  assign bus.stall_timeout    = timeout_q;

  // Arm a one-cycle squash behind a taken branch that actually left ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      squash_q <= 1'b0;
    end else begin
      squash_q <= bus.branch_taken & ~hazard;
    end
  end

  // Track the current run of back-to-back stalls and latch the watchdog
  // once a run outgrows MAX_STALL.
  always_ff @(posedge clk) begin
    if (rst) begin
      consec_q  <= 3'd0;
      timeout_q <= 1'b0;
    end else if (hazard) begin
      if (consec_q != 3'b111) begin
        consec_q <= consec_q + 3'd1;
      end
      if ((int'(consec_q) + 1) > MAX_STALL) begin
        timeout_q <= 1'b1;
      end
    end else begin
      consec_q <= 3'd0;
    end
  end

  // Lifetime stall-cycle count, pinned at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (hazard && (stall_cnt_q != {PERF_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + PERF_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - self-checking bench for hazard_scheduler
module tb_hazard_scheduler;

  logic       clk;
  logic       rst;
  logic       s1u, s2u, we, bt;
  logic [2:0] s1, s2, dst;

  int n_total = 0;
  int n_bad   = 0;
  bit done    = 0;

  // a: defaults, b: WB bypass, c: short watchdog and 2-bit stall counter
  hazard_scheduler_if #(.PERF_W(16)) if_a ();
  hazard_scheduler_if #(.PERF_W(16)) if_b ();
  hazard_scheduler_if #(.PERF_W(2))  if_c ();

  assign if_a.decoding_op_src1 = s1;  assign if_b.decoding_op_src1 = s1;  assign if_c.decoding_op_src1 = s1;
  assign if_a.src1_used        = s1u; assign if_b.src1_used        = s1u; assign if_c.src1_used        = s1u;
  assign if_a.decoding_op_src2 = s2;  assign if_b.decoding_op_src2 = s2;  assign if_c.decoding_op_src2 = s2;
  assign if_a.src2_used        = s2u; assign if_b.src2_used        = s2u; assign if_c.src2_used        = s2u;
  assign if_a.id_op_dest       = dst; assign if_b.id_op_dest       = dst; assign if_c.id_op_dest       = dst;
  assign if_a.id_write_en      = we;  assign if_b.id_write_en      = we;  assign if_c.id_write_en      = we;
  assign if_a.branch_taken     = bt;  assign if_b.branch_taken     = bt;  assign if_c.branch_taken     = bt;

  hazard_scheduler #(.R0_IS_ZERO(1), .WB_BYPASS(0), .MAX_STALL(3), .PERF_W(16)) dut_a (
    .clk (clk), .rst (rst), .bus (if_a));
  hazard_scheduler #(.R0_IS_ZERO(1), .WB_BYPASS(1), .MAX_STALL(3), .PERF_W(16)) dut_b (
    .clk (clk), .rst (rst), .bus (if_b));
  hazard_scheduler #(.R0_IS_ZERO(1), .WB_BYPASS(0), .MAX_STALL(2), .PERF_W(2)) dut_c (
    .clk (clk), .rst (rst), .bus (if_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a log of what each scheduler let out of ID at each cycle. A
  // writer issued a cycles ago (a=1..depth) blocks readers of its register.
  int         byp[3]  = '{0, 1, 0};
  int         mx[3]   = '{3, 3, 2};
  int         tmax[3] = '{65535, 65535, 3};
  int         t         = 0;
  int         rst_after = 1;
  bit         iss_v[3][256];
  bit         iss_we[3][256];
  logic [2:0] iss_d[3][256];
  bit         sq[3];
  int         tot[3];
  int         run[3];
  bit         to[3];

  function automatic bit m_hz(input int k);
    if (sq[k]) return 1'b0;
    for (int a = 1; a <= (byp[k] != 0 ? 2 : 3); a++) begin
      int c;
      c = t - a;
      if (c < rst_after) continue;
      if (!(iss_v[k][c] && iss_we[k][c])) continue;
      if (s1u && s1 != 3'd0 && iss_d[k][c] == s1) return 1'b1;
      if (s2u && s2 != 3'd0 && iss_d[k][c] == s2) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_dest(input int k, input int a);
    int c;
    c = t - a;
    if (c >= rst_after && iss_v[k][c]) return int'(iss_d[k][c]);
    return 0;
  endfunction

  initial begin
    bit sq_n[3];
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        bit h;
        h = m_hz(k);
        iss_v[k][t]  = 1'b0;
        iss_we[k][t] = we;
        iss_d[k][t]  = dst;
        sq_n[k]      = 1'b0;
        if (rst) begin
          tot[k] = 0;
          run[k] = 0;
          to[k]  = 1'b0;
        end else begin
          iss_v[k][t] = !h && !sq[k];
          if (h) begin
            if (tot[k] < tmax[k]) tot[k] = tot[k] + 1;
            if (run[k] + 1 > mx[k]) to[k] = 1'b1;
            if (run[k] < 7) run[k] = run[k] + 1;
          end else begin
            run[k] = 0;
          end
          sq_n[k] = bt && !h;
        end
      end
      for (int k = 0; k < 3; k++) sq[k] = sq_n[k];
      if (rst) rst_after = t + 1;
      t = t + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, t);
    end
  endtask

  task automatic cmp_inst(input int k, input int sn, input int ex, input int mem,
                          input int wb, input int tt, input int tov);
    chk($sformatf("i%0d_stall_n", k), sn, m_hz(k) ? 0 : 1);
    chk($sformatf("i%0d_ex_dest", k), ex, m_dest(k, 1));
    chk($sformatf("i%0d_mem_dest", k), mem, m_dest(k, 2));
    chk($sformatf("i%0d_wb_dest", k), wb, m_dest(k, 3));
    chk($sformatf("i%0d_stall_total", k), tt, tot[k]);
    chk($sformatf("i%0d_timeout", k), tov, int'(to[k]));
  endtask

  // Every-cycle comparison of all three schedulers against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (t >= 1 && !done) begin
        cmp_inst(0, int'(if_a.pipeline_stall_n), int'(if_a.ex_op_dest), int'(if_a.mem_op_dest),
                 int'(if_a.wb_op_dest), int'(if_a.stall_total), int'(if_a.stall_timeout));
        cmp_inst(1, int'(if_b.pipeline_stall_n), int'(if_b.ex_op_dest), int'(if_b.mem_op_dest),
                 int'(if_b.wb_op_dest), int'(if_b.stall_total), int'(if_b.stall_timeout));
        cmp_inst(2, int'(if_c.pipeline_stall_n), int'(if_c.ex_op_dest), int'(if_c.mem_op_dest),
                 int'(if_c.wb_op_dest), int'(if_c.stall_total), int'(if_c.stall_timeout));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL sim_timeout actual=running expected=finished");
    $fatal(1);
  end

  task automatic set_in(input logic r, input logic a1u, input logic [2:0] a1,
                        input logic a2u, input logic [2:0] a2,
                        input logic w, input logic [2:0] d, input logic b);
    rst = r; s1u = a1u; s1 = a1; s2u = a2u; s2 = a2; we = w; dst = d; bt = b;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // c0: reset with idle inputs, stall must already be released
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall_n_a", int'(if_a.pipeline_stall_n), 1);
    chk("rst_stall_n_b", int'(if_b.pipeline_stall_n), 1);
    chk("rst_stall_n_c", int'(if_c.pipeline_stall_n), 1);
    tick;
    // c1 producer r3, c2..c5 consumer of r3
    set_in(0, 0, 0, 0, 0, 1, 3, 0); tick;
    set_in(0, 1, 3, 0, 0, 0, 0, 0);
    chk("dep_c2_stall_a", int'(if_a.pipeline_stall_n), 0);
    tick; tick;
    chk("dep_c4_stall_a", int'(if_a.pipeline_stall_n), 0);
    chk("dep_c4_bypass_b", int'(if_b.pipeline_stall_n), 1);
    tick;
    chk("dep_c5_release_a", int'(if_a.pipeline_stall_n), 1);
    chk("dep_c5_timeout_c", int'(if_c.stall_timeout), 1);
    tick;
    // c6 producer r0, c7..c9 readers of r0
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    chk("dep_total_a", int'(if_a.stall_total), 3);
    chk("dep_total_b", int'(if_b.stall_total), 2);
    chk("dep_total_c", int'(if_c.stall_total), 3);
    chk("dep_timeout_a", int'(if_a.stall_timeout), 0);
    chk("dep_timeout_b", int'(if_b.stall_timeout), 0);
    chk("model_total_a", tot[0], 3);
    tick;
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 1, 0, 0, 0, 0);
      chk("r0_stall_n_a", int'(if_a.pipeline_stall_n), 1);
      tick;
    end
    // c10 taken branch writing r4, c11 shadow slot reads r4 writes r5, c12 reads r5
    set_in(0, 0, 0, 0, 0, 1, 4, 1); tick;
    set_in(0, 1, 4, 0, 0, 1, 5, 0);
    chk("squash_no_stall_a", int'(if_a.pipeline_stall_n), 1);
    tick;
    set_in(0, 1, 5, 0, 0, 0, 0, 0);
    chk("squash_ex_bubble_a", int'(if_a.ex_op_dest), 0);
    chk("squash_mem_dest_a", int'(if_a.mem_op_dest), 4);
    chk("squash_r5_free_a", int'(if_a.pipeline_stall_n), 1);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk("squash_total_a", int'(if_a.stall_total), 3);
    tick;
    // c14 producer r3, c15 consumer, c16 consumer under reset, c17 consumer after reset
    set_in(0, 0, 0, 0, 0, 1, 3, 0); tick;
    set_in(0, 1, 3, 0, 0, 0, 0, 0); tick;
    set_in(1, 1, 3, 0, 0, 0, 0, 0);
    chk("mid_rst_stall_a", int'(if_a.pipeline_stall_n), 0);
    chk("mid_rst_total_a", int'(if_a.stall_total), 4);
    chk("sat_total_c", int'(if_c.stall_total), 3);
    tick;
    set_in(0, 1, 3, 0, 0, 0, 0, 0);
    chk("post_rst_stall_n_a", int'(if_a.pipeline_stall_n), 1);
    chk("post_rst_ex_a", int'(if_a.ex_op_dest), 0);
    chk("post_rst_mem_a", int'(if_a.mem_op_dest), 0);
    chk("post_rst_wb_a", int'(if_a.wb_op_dest), 0);
    chk("post_rst_total_a", int'(if_a.stall_total), 0);
    chk("post_rst_timeout_c", int'(if_c.stall_timeout), 0);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick;
    // c19 writes r1, c20 writes r2, c21..c24 reads r1 and r2
    set_in(0, 0, 0, 0, 0, 1, 1, 0); tick;
    set_in(0, 0, 0, 0, 0, 1, 2, 0); tick;
    set_in(0, 1, 1, 1, 2, 0, 0, 0);
    chk("dual_stall_a", int'(if_a.pipeline_stall_n), 0);
    tick; tick; tick;
    chk("dual_release_a", int'(if_a.pipeline_stall_n), 1);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk("dual_total_a", int'(if_a.stall_total), 3);
    chk("dual_total_b", int'(if_b.stall_total), 2);
    chk("dual_total_c", int'(if_c.stall_total), 3);
    chk("dual_timeout_c", int'(if_c.stall_timeout), 1);
    chk("dual_timeout_a", int'(if_a.stall_timeout), 0);
    tick; tick;
    done = 1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
Central stall scheduler for the 5-stage MIPS16 pipeline. It replaces ad-hoc hazard detection.
- Keeps a 3-deep scoreboard of in-flight destination registers (EX, MEM, WB).
- Compares ID-stage source operands against that scoreboard and drives pipeline_stall_n to IF_stage and ID_stage.
- Squashes the branch shadow slot.
- Keeps stall performance/watchdog counters for the verification bench.

Parameters:
- REG_ADDR_W, 3, register address width.
- R0_IS_ZERO, 1, when 1 a source of r0 never causes a hazard.
- WB_BYPASS, 0, when 1 a WB-stage match is not a hazard (register file write-through).
- MAX_STALL, 3, maximum legal consecutive stall cycles before the watchdog flags.
- PERF_W, 16, width of the total-stall performance counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- decoding_op_src1  input  3  ID source register 1
- src1_used  input  1  instruction in ID reads src1
- decoding_op_src2  input  3  ID source register 2
- src2_used  input  1  instruction in ID reads src2
- id_op_dest  input  3  ID destination register
- id_write_en  input  1  instruction in ID writes id_op_dest
- branch_taken  input  1  ID resolved a taken branch this cycle
- pipeline_stall_n  output  1  0 = hold IF/ID and inject bubble into EX
- ex_op_dest  output  3  scoreboard EX destination (debug)
- mem_op_dest  output  3  scoreboard MEM destination (debug)
- wb_op_dest  output  3  scoreboard WB destination (debug)
- stall_total  output  PERF_W  saturating count of stall cycles since reset
- stall_timeout  output  1  sticky watchdog flag

Behaviour:
- Scoreboard: three registered entries {valid, dest}, named EX, MEM and WB.
- Each cycle the scoreboard shifts: WB <= MEM, MEM <= EX.
- EX load rule:
  - If the stall is asserted or squash is active: EX <= {0, 0}, i.e. a bubble.
  - Otherwise: EX <= {id_write_en, id_op_dest}.
- Match: srcN_used AND valid entry AND dest == srcN.
  - With R0_IS_ZERO=1, a source of 0 never matches.
  - With WB_BYPASS=1, the WB entry is excluded.
- hazard = match of src1 or src2 against any eligible entry. This is combinational from the registered scoreboard plus the current inputs.
- pipeline_stall_n = ~hazard.
- Branch squash: when branch_taken=1 and the stall is deasserted, a squash flag is registered for exactly 1 cycle.
  - While the squash flag is high, the instruction in ID is loaded into EX as a bubble regardless of id_write_en.
  - While the squash flag is high, hazard is forced to 0; the squashed instruction never stalls.
- branch_taken while stalled is ignored. ID re-presents the branch after the stall.
- Consecutive-stall counter (internal, 3 bits, saturating):
  - Increments each stall cycle and clears on any non-stall cycle.
  - When it would exceed MAX_STALL, stall_timeout sets and stays set until reset.
- stall_total increments on every stall cycle and saturates at all-ones (no wrap).
- Reset values:
  - All scoreboard entries valid=0, dest=0.
  - ex/mem/wb_op_dest = 0, squash flag = 0.
  - stall counters = 0, stall_timeout = 0.
  - pipeline_stall_n = 1 whenever no src is used. It is combinational, so it is 1 in the reset cycle if inputs are idle.
- Reset mid-stall: the scoreboard clears on the next edge and the stall releases in the following cycle. No partial state survives.
- Simultaneous src1/src2 hazards: a single stall; duration is set by the younger matching entry draining.
- Latency: a dependent instruction immediately behind a producer stalls 3 cycles (2 with WB_BYPASS=1).

Decomposition:
- MIPS_pkg holds:
  - typedef sb_entry_t {logic valid; logic [2:0] dest;}
  - constant MIPS_REG_ZERO = 3'd0
  - constant MIPS_MAX_STALL = 3
- One natural sub-module: hazard_scoreboard, containing the 3-entry shift register, the bubble-insert logic and the match comparators.
- The top level adds the squash flag, the watchdog and the performance counter.

Test Plan:
1. Reset, then a back-to-back dependency: producer id_write_en=1 dest=3, followed by a consumer with src1_used=1 src1=3.
   - pipeline_stall_n low for exactly 3 cycles, then high.
   - stall_total=3; stall_timeout=0.
2. Same sequence with WB_BYPASS=1: exactly 2 stall cycles; stall_total=2.
3. r0 source: producer dest=0, then consumer src1=0, src2=0 with R0_IS_ZERO=1 → no stall, stall_total stays 0.
4. Branch squash: branch_taken=1 on an unstalled cycle; the next ID instruction has id_write_en=1 dest=5 and src1=any in-flight reg.
   - No stall.
   - ex_op_dest shows a bubble (valid=0) one cycle later.
   - A following read of r5 does not stall.
5. Watchdog: force src1_used=1 src1=2 while the bench holds a valid producer, and inject id_write_en=1 dest=2 via a bench-forced scoreboard.
   - After 4 consecutive stall cycles, stall_timeout=1.
   - stall_timeout stays 1 until rst.
6. Reset mid-stall: assert rst during cycle 2 of scenario 1.
   - Next edge: all *_op_dest=0, stall_total=0.
   - pipeline_stall_n=1 on the following cycle.
